// File: rtl/evm_tally_arbiter.sv
// Session FSM plus round-robin booth arbiter sharing one bank of saturating vote counters.
// Optional EVM_TOTAL_COUNT_EN adds total_votes, a saturating count of successfully tallied votes.
module evm_tally_arbiter #(
    parameter int NB     = 2,
    parameter int NC     = 2,
    parameter int CSEL_W = 3,
    parameter int W      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 open_cmd,
    input  logic                 close_cmd,
    input  logic                 clear_cmd,
    input  logic [NB-1:0]        booth_req,
    input  logic [NB*CSEL_W-1:0] booth_cand,
    output logic [NB-1:0]        booth_ack,
    output logic [1:0]           session_state,
    output logic [NC*W-1:0]      tally,
    output logic                 result_valid,
    output logic                 sat_flag,
    output logic                 invalid_pulse
`ifdef EVM_TOTAL_COUNT_EN
    ,
    output logic [W+2:0]         total_votes
`endif
);

    localparam int PTR_W = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_OPEN   = 2'b01,
        S_CLOSED = 2'b10
    } state_t;

    state_t            state_reg, state_next;
    logic [PTR_W-1:0]  rr_ptr_reg;
    logic [NB-1:0]     served_reg;
    logic [NB-1:0]     booth_ack_reg;
    logic [W-1:0]      tally_reg [NC];
    logic              sat_flag_reg;
    logic              invalid_pulse_reg;

    logic              grant_allowed;
    logic              clear_en;
    logic              grant_en;
    logic [PTR_W-1:0]  grant_idx;
    logic [NB-1:0]     grant_onehot;
    logic [NB-1:0]     eligible;
    logic [CSEL_W-1:0] grant_cand;
    logic              grant_valid_cand;
    logic [NC-1:0]     cand_hit;
    logic [NC-1:0]     cand_full;
    logic              inc_ok;
    logic              sat_hit;
    int                scan;

    // Session FSM: only the command meaningful in the current state is acted on.
    always_comb begin
        state_next    = state_reg;
        grant_allowed = 1'b0;
        clear_en      = 1'b0;
        case (state_reg)
            S_IDLE:   if (open_cmd) state_next = S_OPEN;
            S_OPEN: begin
                if (close_cmd) state_next = S_CLOSED;
                else           grant_allowed = 1'b1;
            end
            S_CLOSED: begin
                if (clear_cmd) begin
                    state_next = S_IDLE;
                    clear_en   = 1'b1;
                end
            end
            default:  state_next = S_IDLE;
        endcase
    end

    // Round-robin scan from rr_ptr; a booth already served must drop req before voting again.
    always_comb begin
        eligible  = booth_req & ~served_reg;
        grant_en  = 1'b0;
        grant_idx = '0;
        scan      = 0;
        for (int k = 0; k < NB; k++) begin
            scan = (int'(rr_ptr_reg) + k) % NB;
            if (grant_allowed && !grant_en && eligible[scan]) begin
                grant_en  = 1'b1;
                grant_idx = PTR_W'(scan);
            end
        end
    end

    assign grant_onehot     = grant_en ? (NB'(1) << grant_idx) : '0;
    assign grant_cand       = booth_cand[int'(grant_idx)*CSEL_W +: CSEL_W];
    assign grant_valid_cand = (int'(grant_cand) < NC);

    genvar gi;
    generate
        for (gi = 0; gi < NC; gi++) begin : g_cand
            assign cand_hit[gi]        = grant_en && grant_valid_cand && (int'(grant_cand) == gi);
            assign cand_full[gi]       = (tally_reg[gi] == {W{1'b1}});
            assign tally[gi*W +: W]    = tally_reg[gi];
        end
    endgenerate

    assign inc_ok  = |(cand_hit & ~cand_full);
    assign sat_hit = |(cand_hit & cand_full);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= S_IDLE;
            rr_ptr_reg        <= '0;
            served_reg        <= '0;
            booth_ack_reg     <= '0;
            sat_flag_reg      <= 1'b0;
            invalid_pulse_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            booth_ack_reg     <= grant_onehot;
            invalid_pulse_reg <= grant_en && !grant_valid_cand;
            served_reg        <= (served_reg & booth_req) | grant_onehot;
            if (grant_en)
                rr_ptr_reg <= (grant_idx == PTR_W'(NB-1)) ? '0 : grant_idx + 1'b1;
            if (sat_hit)
                sat_flag_reg <= 1'b1;
            if (clear_en) begin
                served_reg   <= '0;
                rr_ptr_reg   <= '0;
                sat_flag_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NC; c++) begin
            if (rst || clear_en)
                tally_reg[c] <= '0;
            else if (cand_hit[c] && !cand_full[c])
                tally_reg[c] <= tally_reg[c] + 1'b1;
        end
    end

`ifdef EVM_TOTAL_COUNT_EN
    logic [W+2:0] total_votes_reg;

    always_ff @(posedge clk) begin
        if (rst || clear_en)
            total_votes_reg <= '0;
        else if (inc_ok && (total_votes_reg != {(W+3){1'b1}}))
            total_votes_reg <= total_votes_reg + 1'b1;
    end

    assign total_votes = total_votes_reg;
`endif

    assign booth_ack     = booth_ack_reg;
    assign session_state = state_reg;
    assign result_valid  = (state_reg == S_CLOSED);
    assign sat_flag      = sat_flag_reg;
    assign invalid_pulse = invalid_pulse_reg;

endmodule

// File: tb/tb_evm_tally_arbiter.sv
// Directed bench for evm_tally_arbiter (NB=2, NC=2, CSEL_W=3, W=4) with hand-computed expectations.
module tb_evm_tally_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       open_cmd, close_cmd, clear_cmd;
    logic [1:0] booth_req;
    logic [5:0] booth_cand;
    logic [1:0] booth_ack;
    logic [1:0] session_state;
    logic [7:0] tally;
    logic       result_valid, sat_flag, invalid_pulse;
`ifdef EVM_TOTAL_COUNT_EN
    logic [6:0] total_votes;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    evm_tally_arbiter #(.NB(2), .NC(2), .CSEL_W(3), .W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .open_cmd      (open_cmd),
        .close_cmd     (close_cmd),
        .clear_cmd     (clear_cmd),
        .booth_req     (booth_req),
        .booth_cand    (booth_cand),
        .booth_ack     (booth_ack),
        .session_state (session_state),
        .tally         (tally),
        .result_valid  (result_valid),
        .sat_flag      (sat_flag),
        .invalid_pulse (invalid_pulse)
`ifdef EVM_TOTAL_COUNT_EN
        ,
        .total_votes   (total_votes)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
            $display("[tb] %s observed=%0h expected=%0h ok", tag, obs, exp);
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; open_cmd = 1'b0; close_cmd = 1'b0; clear_cmd = 1'b0;
        booth_req = 2'b00; booth_cand = 6'b000_000;
        tick(); tick();
        check("rst_state", session_state, 2'b00);
        check("rst_tally", tally, 8'h00);
        check("rst_ack", booth_ack, 2'b00);
        check("rst_rv", result_valid, 1'b0);
        check("rst_sat", sat_flag, 1'b0);
        check("rst_inv", invalid_pulse, 1'b0);
        rst = 1'b0;

        // IDLE ignores close and requests
        close_cmd = 1'b1; tick(); close_cmd = 1'b0;
        check("idle_close_ignored", session_state, 2'b00);
        booth_req = 2'b01; booth_cand = {3'd0, 3'd1};
        tick();
        check("idle_no_ack", booth_ack, 2'b00);

        open_cmd = 1'b1; tick(); open_cmd = 1'b0;
        check("open_state", session_state, 2'b01);
        check("open_edge_no_ack", booth_ack, 2'b00);

        tick();
        check("b0_ack", booth_ack, 2'b01);
        check("b0_tally", tally, 8'h10);
        tick();
        check("b0_held_no_ack", booth_ack, 2'b00);
        check("b0_held_tally", tally, 8'h10);
        booth_req = 2'b00; tick();

        // invalid candidate from booth1
        booth_req = 2'b10; booth_cand = {3'd5, 3'd0};
        tick();
        check("inv_ack", booth_ack, 2'b10);
        check("inv_pulse", invalid_pulse, 1'b1);
        check("inv_tally", tally, 8'h10);
        booth_req = 2'b00; tick();
        check("inv_pulse_1cyc", invalid_pulse, 1'b0);

        // alternation, rr_ptr = 0: booth0 -> cand0, booth1 -> cand1
        booth_cand = {3'd1, 3'd0};
        booth_req = 2'b11; tick(); check("rr_e1", booth_ack, 2'b01);
        booth_req = 2'b10; tick(); check("rr_e2", booth_ack, 2'b10);
        booth_req = 2'b01; tick(); check("rr_e3", booth_ack, 2'b01);
        booth_req = 2'b10; tick(); check("rr_e4", booth_ack, 2'b10);
        check("rr_tally", tally, 8'h32);
        booth_req = 2'b00; tick();

        // both eligible with rr_ptr = 1 -> booth1 wins, then booth0
        booth_req = 2'b01; tick(); check("rr_e6", booth_ack, 2'b01);
        booth_req = 2'b00; tick();
        booth_req = 2'b11; tick(); check("rr_tie_b1", booth_ack, 2'b10);
        tick(); check("rr_tie_b0", booth_ack, 2'b01);
        check("rr_tally2", tally, 8'h44);
        booth_req = 2'b00; tick();

        // close wins over a same-cycle request
        booth_req = 2'b01; close_cmd = 1'b1; tick(); close_cmd = 1'b0;
        check("close_state", session_state, 2'b10);
        check("close_no_ack", booth_ack, 2'b00);
        check("close_rv", result_valid, 1'b1);
        open_cmd = 1'b1; tick(); open_cmd = 1'b0;
        check("closed_open_ignored", session_state, 2'b10);
        check("closed_no_ack", booth_ack, 2'b00);
        check("closed_frozen", tally, 8'h44);
        clear_cmd = 1'b1; tick(); clear_cmd = 1'b0;
        check("clear_state", session_state, 2'b00);
        check("clear_tally", tally, 8'h00);
        check("clear_rv", result_valid, 1'b0);
        booth_req = 2'b00;

        // saturation on cand0
        open_cmd = 1'b1; tick(); open_cmd = 1'b0;
        booth_cand = {3'd1, 3'd0};
        for (int v = 1; v <= 16; v++) begin
            booth_req = 2'b01; tick();
            check($sformatf("sat_ack_%0d", v), booth_ack, 2'b01);
            if (v == 15) begin
                check("sat_t15", tally, 8'h0F);
                check("sat_flag_15", sat_flag, 1'b0);
            end
            booth_req = 2'b00; tick();
        end
        check("sat_t16", tally, 8'h0F);
        check("sat_flag_16", sat_flag, 1'b1);
`ifdef EVM_TOTAL_COUNT_EN
        check("total_sat", total_votes, 7'd15);
`endif
        clear_cmd = 1'b1; tick(); clear_cmd = 1'b0;
        check("open_clear_ignored", session_state, 2'b01);
        check("sat_sticky", sat_flag, 1'b1);

        // reset mid-session
        rst = 1'b1; tick(); rst = 1'b0;
        open_cmd = 1'b1; tick(); open_cmd = 1'b0;
        for (int v = 0; v < 3; v++) begin
            booth_req = 2'b01; tick();
            booth_req = 2'b00; tick();
        end
        check("mid_tally3", tally, 8'h03);
        booth_req = 2'b01; rst = 1'b1; tick(); rst = 1'b0;
        check("mid_rst_state", session_state, 2'b00);
        check("mid_rst_tally", tally, 8'h00);
        check("mid_rst_ack", booth_ack, 2'b00);
        check("mid_rst_sat", sat_flag, 1'b0);
        check("mid_rst_inv", invalid_pulse, 1'b0);
        check("mid_rst_rv", result_valid, 1'b0);
`ifdef EVM_TOTAL_COUNT_EN
        check("mid_rst_total", total_votes, 7'd0);
`endif
        booth_req = 2'b00;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/evm_tally_arbiter.md
Name: evm_tally_arbiter

Overview:
Session controller and round-robin arbiter that lets NB voting booths share one bank of NC candidate vote counters. A session FSM (IDLE/OPEN/CLOSED) gates when votes are accepted and when results are published. Per cycle, at most one booth request is granted, acknowledged and tallied. The block sits between the booth button logic and the result display/readout.

Parameters:
NB, 2, number of booths (2..8)
NC, 2, number of candidates (2..8)
CSEL_W, 3, width of the candidate index per booth
W, 4, width of each candidate counter

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
open_cmd  input  1  presiding-officer pulse: open the session
close_cmd  input  1  presiding-officer pulse: close the session
clear_cmd  input  1  clear results and return to IDLE (only honoured in CLOSED)
booth_req  input  NB  per-booth vote request; held high until ack
booth_cand  input  NB*CSEL_W  per-booth candidate index; booth i at bits [i*CSEL_W +: CSEL_W]; stable while req high
booth_ack  output  NB  one-hot, one-cycle acknowledge to the granted booth
session_state  output  2  00 IDLE, 01 OPEN, 10 CLOSED
tally  output  NC*W  candidate counters; candidate c at bits [c*W +: W]
result_valid  output  1  high in CLOSED only
sat_flag  output  1  sticky: a counter hit 2^W-1 and a further vote was dropped
invalid_pulse  output  1  one-cycle pulse: the granted request carried index >= NC

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, tally=0, booth_ack=0, result_valid=0, sat_flag=0, invalid_pulse=0, rr_ptr=0, served mask=0. Reset mid-session discards all counts.
- IDLE: tally held at 0. open_cmd -> OPEN. close_cmd and clear_cmd ignored. Requests are ignored and not acked.
- OPEN:
  - Eligible booths are those with req=1 and served=0.
  - Round-robin scan starts at rr_ptr. The first eligible booth i wins.
  - Registered outputs (request sampled at edge t, visible after t+1):
    - booth_ack[i]=1 for exactly one cycle.
    - served[i] is set; rr_ptr becomes (i+1) mod NB.
    - If booth_cand[i] < NC: tally[cand] increments. If the counter is already 2^W-1, it holds and sat_flag is set.
    - If booth_cand[i] >= NC: no counter changes and invalid_pulse=1.
  - served[i] clears when booth_req[i] is seen low. This blocks a held button from voting twice.
  - close_cmd -> CLOSED. The close has priority: no grant is issued in that cycle, and pending requests stay un-acked.
  - open_cmd in OPEN is ignored.
- CLOSED: tally frozen, result_valid=1, no acks. clear_cmd -> IDLE with tally=0, sat_flag=0, served=0, rr_ptr=0. open_cmd and close_cmd are ignored.
- Simultaneous commands in the same cycle: the command valid for the current state wins; any other command is ignored.
- Throughput: one vote per cycle across all booths. The worst-case wait for any booth is NB cycles.

Optional Feature:
EVM_TOTAL_COUNT_EN
- Defined: adds output total_votes [W+2:0], a saturating count of valid votes. It is cleared on reset and on clear_cmd, and incremented alongside any successful tally increment. Saturated or invalid votes do not count.
- Undefined: the port and its logic are absent.

Test Plan:
- Reset, then open_cmd. Booth0 holds req with cand=1 -> ack0 pulses 1 cycle after the request is sampled; tally cand1=1, cand0=0; booth0 still high -> no second ack.
- Booths 0 and 1 request together continuously (dropping req for 1 cycle after each ack) with rr_ptr=0 -> ack order 0,1,0,1; each booth gets 2 votes in 4 grants.
- Booth1 sends cand=5 with NC=2 -> ack1=1, invalid_pulse=1, tally unchanged.
- W=4: 16 votes for cand0 -> tally0=15, sat_flag=1.
- close_cmd in the same cycle as booth0 req -> state=10, no ack, result_valid=1. open_cmd then has no effect; clear_cmd -> state=00, tally=0.
- rst asserted while OPEN with tally0=3 -> next cycle state=00, all outputs 0.
